driver_seq: RTL and testbench

Program sequencer between the driver control register block and the vector-memory read port. On a run command it pops base addresses from the address FIFO and issues each as a single request or a burst of consecutive word requests. Request issue is throttled by vector-FIFO fill level and freeze controls. It ends gracefully on end, or immediately on abort, and reports activity and a beat count back for status readout.

---
 rtl/driver_seq.sv | 150 +++++++++++++++
 tb/tb_driver_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_seq.sv
// Program sequencer: pops base addresses from the address FIFO and issues single or burst
// word requests to the vector-memory read port. Define DRIVER_SEQ_STATS_EN for stall statistics.
module driver_seq #(
  parameter int unsigned VCTR_FIFO_DEPTH = 512,
  parameter int unsigned VCTR_HEADROOM   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_program,
  input  logic        end_program,
  input  logic        abort_program,
  input  logic        freeze_addr_fifo,
  input  logic        freeze_vector_fifo,
  input  logic        send_consec_addr,
  input  logic [7:0]  consec_count,
  input  logic [31:0] addr_fifo_dout,
  input  logic        addr_fifo_empty,
  output logic        addr_fifo_rd,
  input  logic [15:0] words_in_vctr_fifo,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  output logic        active_program,
  output logic        prog_done,
  output logic        prog_aborted,
  output logic [15:0] addr_cycle_cnt,
  output logic [15:0] stall_cycle_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEAT_W = 8;
  localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(VCTR_FIFO_DEPTH - VCTR_HEADROOM);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, ISSUE} state_t;

  state_t              state;
  logic                run_q;
  logic                run_qq;
  logic [BEAT_W-1:0]   beat_idx;
  logic [BEAT_W-1:0]   beat_last;

  logic run_rise_c;
  logic issue_ok_c;
  logic handshake_c;
  logic last_beat_c;

  assign run_rise_c  = run_q && !run_qq;
  assign issue_ok_c  = !freeze_vector_fifo && (words_in_vctr_fifo < FILL_LIMIT);
  assign handshake_c = req_valid && req_ready;
  assign last_beat_c = (beat_idx == beat_last);

  // Sequencer FSM; req_addr tracks base + 4*beat_idx by incrementing per accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      run_q          <= 1'b0;
      run_qq         <= 1'b0;
      beat_idx       <= '0;
      beat_last      <= '0;
      addr_fifo_rd   <= 1'b0;
      req_valid      <= 1'b0;
      req_addr       <= '0;
      active_program <= 1'b0;
      prog_done      <= 1'b0;
      prog_aborted   <= 1'b0;
      addr_cycle_cnt <= '0;
    end else begin
      run_q        <= run_program;
      run_qq       <= run_q;
      addr_fifo_rd <= 1'b0;
      prog_done    <= 1'b0;
      prog_aborted <= 1'b0;

      if (state != IDLE && abort_program) begin
        state          <= IDLE;
        req_valid      <= 1'b0;
        active_program <= 1'b0;
        prog_aborted   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (run_rise_c) begin
              state          <= FETCH;
              active_program <= 1'b1;
              addr_cycle_cnt <= '0;
            end
          end
          FETCH: begin
            if (end_program) begin
              state          <= IDLE;
              active_program <= 1'b0;
              prog_done      <= 1'b1;
            end else if (!addr_fifo_empty && !freeze_addr_fifo) begin
              addr_fifo_rd <= 1'b1;
              state        <= LOAD;
            end
          end
          LOAD: begin
            req_addr  <= addr_fifo_dout;
            beat_idx  <= '0;
            beat_last <= send_consec_addr ? consec_count : '0;
            req_valid <= issue_ok_c;
            state     <= ISSUE;
          end
          ISSUE: begin
            if (!req_valid) begin
              req_valid <= issue_ok_c;
            end else if (handshake_c) begin
              if (addr_cycle_cnt != '1) begin
                addr_cycle_cnt <= addr_cycle_cnt + CNT_W'(1);
              end
              if (last_beat_c) begin
                req_valid <= 1'b0;
                if (end_program) begin
                  state          <= IDLE;
                  active_program <= 1'b0;
                  prog_done      <= 1'b1;
                end else begin
                  state <= FETCH;
                end
              end else begin
                beat_idx  <= beat_idx + BEAT_W'(1);
                req_addr  <= req_addr + ADDR_W'(4);
                req_valid <= issue_ok_c;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DRIVER_SEQ_STATS_EN
  // Every ISSUE cycle without an accepted beat is a stall (throttled or back-pressured).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycle_cnt <= '0;
    end else if (state == IDLE && run_rise_c) begin
      stall_cycle_cnt <= '0;
    end else if (state == ISSUE && !handshake_c && stall_cycle_cnt != '1) begin
      stall_cycle_cnt <= stall_cycle_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_driver_seq.sv
// Self-checking bench for driver_seq: directed scenarios plus randomized programs checked
// against an address-list reference model.
module tb_driver_seq;

  localparam int unsigned DEPTH    = 512;
  localparam int unsigned HEADROOM = 16;
  localparam int unsigned LIMIT    = DEPTH - HEADROOM;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_program;
  logic        end_program;
  logic        abort_program;
  logic        freeze_addr_fifo;
  logic        freeze_vector_fifo;
  logic        send_consec_addr;
  logic [7:0]  consec_count;
  logic [31:0] addr_fifo_dout = 32'h0;
  logic        addr_fifo_empty = 1'b1;
  logic        addr_fifo_rd;
  logic [15:0] words_in_vctr_fifo;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        active_program;
  logic        prog_done;
  logic        prog_aborted;
  logic [15:0] addr_cycle_cnt;
  logic [15:0] stall_cycle_cnt;

  int passed = 0;
  int total  = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] obs_q[$];

  driver_seq #(.VCTR_FIFO_DEPTH(DEPTH), .VCTR_HEADROOM(HEADROOM)) dut (
    .clk(clk), .reset(reset), .run_program(run_program), .end_program(end_program),
    .abort_program(abort_program), .freeze_addr_fifo(freeze_addr_fifo),
    .freeze_vector_fifo(freeze_vector_fifo), .send_consec_addr(send_consec_addr),
    .consec_count(consec_count), .addr_fifo_dout(addr_fifo_dout),
    .addr_fifo_empty(addr_fifo_empty), .addr_fifo_rd(addr_fifo_rd),
    .words_in_vctr_fifo(words_in_vctr_fifo), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .active_program(active_program), .prog_done(prog_done),
    .prog_aborted(prog_aborted), .addr_cycle_cnt(addr_cycle_cnt),
    .stall_cycle_cnt(stall_cycle_cnt)
  );

  always #5 clk = ~clk;

  // Address FIFO model: data appears in the cycle after the pop strobe.
  always @(negedge clk) begin
    if (addr_fifo_rd === 1'b1 && fifo_q.size() > 0) addr_fifo_dout = fifo_q.pop_front();
    addr_fifo_empty = (fifo_q.size() == 0);
  end

  // Record beats that will be accepted on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && req_valid === 1'b1 && req_ready && !abort_program) obs_q.push_back(req_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    run_program = 1'b0; end_program = 1'b0; abort_program = 1'b0;
    freeze_addr_fifo = 1'b0; freeze_vector_fifo = 1'b0; send_consec_addr = 1'b0;
    consec_count = 8'd0; words_in_vctr_fifo = 16'd0; req_ready = 1'b0;
  endtask

  task automatic start_to_issue();
    run_program = 1'b1; step(); run_program = 1'b0;
    step(); step(); step();
  endtask

  task automatic stop_prog();
    end_program = 1'b1;
    for (int i = 0; i < 20 && !prog_done; i++) step();
    end_program = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++; if (req_valid !== 1'b0 || addr_fifo_rd !== 1'b0) $display("FAIL reset_valid_rd got=%b%b exp=00", req_valid, addr_fifo_rd); else passed++;
    total++; if (req_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", req_addr); else passed++;
    total++; if (active_program !== 1'b0 || prog_done !== 1'b0 || prog_aborted !== 1'b0) $display("FAIL reset_status got=%b%b%b exp=000", active_program, prog_done, prog_aborted); else passed++;
    total++; if (addr_cycle_cnt !== 16'h0 || stall_cycle_cnt !== 16'h0) $display("FAIL reset_counters got=%h/%h exp=0/0", addr_cycle_cnt, stall_cycle_cnt); else passed++;
    step(); step();
    reset = 1'b0;
    step(); step();
    total++; if (active_program !== 1'b0 || req_valid !== 1'b0) $display("FAIL reset_idle got=%b%b exp=00", active_program, req_valid); else passed++;
  endtask

  task automatic test_single();
    set_defaults(); obs_q.delete();
    fifo_q.push_back(32'h0000_1000);
    req_ready = 1'b1;
    step();
    run_program = 1'b1; step(); run_program = 1'b0;
    step();
    total++; if (active_program !== 1'b1 || addr_fifo_rd !== 1'b0) $display("FAIL single_start got=%b%b exp=10", active_program, addr_fifo_rd); else passed++;
    step();
    total++; if (addr_fifo_rd !== 1'b1) $display("FAIL single_pop got=%b exp=1", addr_fifo_rd); else passed++;
    step();
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_1000 || addr_fifo_rd !== 1'b0) $display("FAIL single_req got=%b %h exp=1 00001000", req_valid, req_addr); else passed++;
    step();
    total++; if (req_valid !== 1'b0 || addr_cycle_cnt !== 16'd1) $display("FAIL single_after got=%b %0d exp=0 1", req_valid, addr_cycle_cnt); else passed++;
    end_program = 1'b1; step();
    total++; if (prog_done !== 1'b1 || active_program !== 1'b0 || prog_aborted !== 1'b0) $display("FAIL single_done got=%b%b%b exp=100", prog_done, active_program, prog_aborted); else passed++;
    step(); end_program = 1'b0;
    total++; if (prog_done !== 1'b0) $display("FAIL single_done_pulse got=%b exp=0", prog_done); else passed++;
    total++; if (obs_q.size() != 1 || obs_q[0] !== 32'h0000_1000) $display("FAIL single_beats got=%0d exp=1", obs_q.size()); else passed++;
  endtask

  task automatic test_burst_wrap();
    logic [31:0] exp;
    set_defaults(); obs_q.delete();
    fifo_q.push_back(32'hFFFF_FFF8);
    send_consec_addr = 1'b1; consec_count = 8'd3; req_ready = 1'b1;
    step();
    start_to_issue();
    for (int k = 0; k < 4; k++) begin
      exp = 32'hFFFF_FFF8 + 32'(4 * k);
      total++; if (req_valid !== 1'b1 || req_addr !== exp) $display("FAIL burst_beat%0d got=%b %h exp=1 %h", k, req_valid, req_addr, exp); else passed++;
      step();
    end
    total++; if (req_valid !== 1'b0 || addr_cycle_cnt !== 16'd4) $display("FAIL burst_count got=%b %0d exp=0 4", req_valid, addr_cycle_cnt); else passed++;
    stop_prog();
  endtask

  task automatic test_throttle();
    set_defaults(); obs_q.delete();
    fifo_q.push_back(32'h0000_2000);
    words_in_vctr_fifo = 16'(LIMIT); req_ready = 1'b1;
    step();
    start_to_issue();
    for (int i = 0; i < 4; i++) begin
      total++; if (req_valid !== 1'b0) $display("FAIL throttle_hold%0d got=%b exp=0", i, req_valid); else passed++;
      step();
    end
    words_in_vctr_fifo = 16'(LIMIT - 1);
    step();
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_2000) $display("FAIL throttle_release got=%b %h exp=1 00002000", req_valid, req_addr); else passed++;
    step();
    total++; if (addr_cycle_cnt !== 16'd1) $display("FAIL throttle_count got=%0d exp=1", addr_cycle_cnt); else passed++;
    stop_prog();
  endtask

  task automatic test_hold();
    logic [15:0] exp_stall;
`ifdef DRIVER_SEQ_STATS_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    set_defaults(); obs_q.delete();
    fifo_q.push_back(32'h0000_3000);
    step();
    start_to_issue();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) freeze_vector_fifo = 1'b1;
      step();
      total++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_3000) $display("FAIL hold_cycle%0d got=%b %h exp=1 00003000", i, req_valid, req_addr); else passed++;
    end
    total++; if (stall_cycle_cnt !== exp_stall) $display("FAIL hold_stall got=%0d exp=%0d", stall_cycle_cnt, exp_stall); else passed++;
    req_ready = 1'b1;
    step();
    total++; if (req_valid !== 1'b0 || addr_cycle_cnt !== 16'd1) $display("FAIL hold_accept got=%b %0d exp=0 1", req_valid, addr_cycle_cnt); else passed++;
    total++; if (stall_cycle_cnt !== exp_stall) $display("FAIL hold_stall_after got=%0d exp=%0d", stall_cycle_cnt, exp_stall); else passed++;
    freeze_vector_fifo = 1'b0;
    stop_prog();
  endtask

  task automatic test_abort();
    set_defaults(); obs_q.delete();
    fifo_q.push_back(32'h0000_4000);
    send_consec_addr = 1'b1; consec_count = 8'd7; req_ready = 1'b1;
    step();
    start_to_issue();
    step(); step();
    abort_program = 1'b1; req_ready = 1'b0;
    step();
    total++; if (req_valid !== 1'b0) $display("FAIL abort_valid got=%b exp=0", req_valid); else passed++;
    total++; if (prog_aborted !== 1'b1 || prog_done !== 1'b0 || active_program !== 1'b0) $display("FAIL abort_status got=%b%b%b exp=100", prog_aborted, prog_done, active_program); else passed++;
    total++; if (addr_cycle_cnt !== 16'd2 || obs_q.size() != 2) $display("FAIL abort_count got=%0d/%0d exp=2/2", addr_cycle_cnt, obs_q.size()); else passed++;
    abort_program = 1'b0;
    step();
    total++; if (prog_aborted !== 1'b0 || prog_done !== 1'b0) $display("FAIL abort_pulse got=%b%b exp=00", prog_aborted, prog_done); else passed++;
  endtask

  task automatic test_end_mid_burst();
    int waited;
    set_defaults(); obs_q.delete();
    fifo_q.push_back(32'h0000_5000);
    send_consec_addr = 1'b1; consec_count = 8'd3; req_ready = 1'b1;
    step();
    start_to_issue();
    step();
    end_program = 1'b1;
    total++; if (prog_done !== 1'b0 || req_valid !== 1'b1) $display("FAIL end_early got=%b%b exp=01", prog_done, req_valid); else passed++;
    waited = 0;
    while (!prog_done && waited < 20) begin step(); waited++; end
    total++; if (prog_done !== 1'b1) $display("FAIL end_timeout got=%b exp=1", prog_done); else passed++;
    total++; if (obs_q.size() != 4 || addr_cycle_cnt !== 16'd4) $display("FAIL end_beats got=%0d/%0d exp=4/4", obs_q.size(), addr_cycle_cnt); else passed++;
    total++; if (obs_q.size() == 4 && obs_q[3] !== 32'h0000_500C) $display("FAIL end_last_addr got=%h exp=0000500c", obs_q[3]); else passed++;
    total++; if (active_program !== 1'b0) $display("FAIL end_active got=%b exp=0", active_program); else passed++;
    end_program = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    set_defaults(); obs_q.delete();
    fifo_q.push_back(32'h0000_6000);
    send_consec_addr = 1'b1; consec_count = 8'd3;
    step();
    start_to_issue();
    total++; if (req_valid !== 1'b1 || active_program !== 1'b1) $display("FAIL areset_pre got=%b%b exp=11", req_valid, active_program); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (req_valid !== 1'b0 || req_addr !== 32'h0) $display("FAIL areset_req got=%b %h exp=0 0", req_valid, req_addr); else passed++;
    total++; if (active_program !== 1'b0 || prog_done !== 1'b0 || prog_aborted !== 1'b0) $display("FAIL areset_status got=%b%b%b exp=000", active_program, prog_done, prog_aborted); else passed++;
    total++; if (addr_cycle_cnt !== 16'h0 || stall_cycle_cnt !== 16'h0 || addr_fifo_rd !== 1'b0) $display("FAIL areset_counters got=%h/%h/%b exp=0/0/0", addr_cycle_cnt, stall_cycle_cnt, addr_fifo_rd); else passed++;
    fifo_q.delete();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] base;
    logic [31:0] pa;
    logic [15:0] pw;
    logic        pv, pr, pf;
    int          n, beats, cyc, waited;
    for (int p = 0; p < 6; p++) begin
      set_defaults(); obs_q.delete(); exp_q.delete();
      n = int'($urandom_range(1, 4));
      send_consec_addr = 1'($urandom_range(0, 1));
      consec_count = 8'($urandom_range(0, 5));
      beats = send_consec_addr ? int'(consec_count) + 1 : 1;
      for (int i = 0; i < n; i++) begin
        base = $urandom;
        if (p == 0 && i == 0) base = 32'hFFFF_FFF4;
        fifo_q.push_back(base);
        for (int k = 0; k < beats; k++) exp_q.push_back(base + 32'(4 * k));
      end
      step();
      run_program = 1'b1; step(); run_program = 1'b0;
      cyc = 0;
      while (obs_q.size() < exp_q.size() && cyc < 3000) begin
        req_ready = ($urandom_range(0, 3) != 0);
        words_in_vctr_fifo = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(LIMIT, LIMIT + 40))
                                                          : 16'($urandom_range(0, LIMIT - 1));
        freeze_vector_fifo = ($urandom_range(0, 7) == 0);
        freeze_addr_fifo = ($urandom_range(0, 7) == 0);
        pv = req_valid; pr = req_ready; pa = req_addr; pw = words_in_vctr_fifo; pf = freeze_vector_fifo;
        step();
        if (pv && !pr) begin
          total++; if (req_valid !== 1'b1 || req_addr !== pa) $display("FAIL rand_hold p%0d got=%b %h exp=1 %h", p, req_valid, req_addr, pa); else passed++;
        end
        if (!pv && req_valid === 1'b1) begin
          total++; if (!(pw < 16'(LIMIT)) || pf) $display("FAIL rand_throttle p%0d got=words %0d freeze %b exp=below %0d unfrozen", p, pw, pf, LIMIT); else passed++;
        end
        cyc++;
      end
      total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_beats p%0d got=%0d exp=%0d", p, obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_addr p%0d beat%0d got=%h exp=%h", p, i, obs_q[i], exp_q[i]); else passed++;
      end
      req_ready = 1'b0; freeze_addr_fifo = 1'b0; freeze_vector_fifo = 1'b0; words_in_vctr_fifo = 16'd0;
      end_program = 1'b1;
      waited = 0;
      while (!prog_done && waited < 20) begin step(); waited++; end
      total++; if (prog_done !== 1'b1) $display("FAIL rand_done p%0d got=%b exp=1", p, prog_done); else passed++;
      total++; if (addr_cycle_cnt !== 16'(exp_q.size())) $display("FAIL rand_count p%0d got=%0d exp=%0d", p, addr_cycle_cnt, exp_q.size()); else passed++;
      end_program = 1'b0;
      fifo_q.delete();
      step();
    end
  endtask

  initial begin
    set_defaults();
    test_reset();
    test_single();
    test_burst_wrap();
    test_throttle();
    test_hold();
    test_abort();
    test_end_mid_burst();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
